// File: rtl/claw_axis_stepper_if.sv
// Signal bundle between the claw clock divider / limit switches and one stepper axis.
// The master side drives step clock, command and limits; the slave side is the axis stepper.
interface claw_axis_stepper_if #(
    parameter int POS_W = 16
);
    logic             step_clk;
    logic [1:0]       cmd;
    logic             lim_lo;
    logic             lim_hi;
    logic [3:0]       coil;
    logic [POS_W-1:0] position;
    logic             homed;
    logic             busy;
    logic             at_limit;
    logic             fault;

    modport master (
        output step_clk, cmd, lim_lo, lim_hi,
        input  coil, position, homed, busy, at_limit, fault
    );

    modport slave (
        input  step_clk, cmd, lim_lo, lim_hi,
        output coil, position, homed, busy, at_limit, fault
    );
endinterface

// File: rtl/claw_axis_stepper.sv
// One claw-game stepper axis: synchronizes the divided step clock and limit switches,
// walks a 4-phase coil pattern, tracks absolute position and handles homing / faults.
module claw_axis_stepper #(
    parameter int POS_W     = 16,
    parameter int POS_MAX   = 4000,
    parameter int HALF_STEP = 1,
    parameter int HOME_MAX  = 8191
) (
    input  logic               clk,
    input  logic               rst,
    claw_axis_stepper_if.slave axis
);

    localparam int               HC_W       = $clog2(HOME_MAX + 1);
    localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
    localparam logic [HC_W-1:0]  HOME_MAX_V = HC_W'(HOME_MAX);
    localparam logic [2:0]       STEP_INC   = (HALF_STEP != 0) ? 3'd1 : 3'd2;

    typedef enum logic [2:0] {
        ST_UNHOMED = 3'd0,
        ST_HOMING  = 3'd1,
        ST_IDLE    = 3'd2,
        ST_FWD     = 3'd3,
        ST_REV     = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             homed_q, homed_d;
    logic [HC_W-1:0]  hcnt_q, hcnt_d;
    logic [3:0]       coil_q, coil_d;
    logic             busy_q, busy_d;
    logic             at_limit_q, at_limit_d;
    logic             fault_q, fault_d;

    logic step_s1_q, step_s2_q, step_s3_q;
    logic step_s1_d, step_s2_d, step_s3_d;
    logic lo_s1_q, lo_s2_q, hi_s1_q, hi_s2_q;
    logic lo_s1_d, lo_s2_d, hi_s1_d, hi_s2_d;

    logic tick;
    logic lo_sync;
    logic hi_sync;

    function automatic logic [3:0] phase_coil(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    // Two-flop synchronizers; the extra step flop turns a rising edge into a one-clk tick.
    always_comb begin
        step_s1_d = axis.step_clk;
        step_s2_d = step_s1_q;
        step_s3_d = step_s2_q;
        lo_s1_d   = axis.lim_lo;
        lo_s2_d   = lo_s1_q;
        hi_s1_d   = axis.lim_hi;
        hi_s2_d   = hi_s1_q;
    end

    assign tick    = step_s2_q & ~step_s3_q;
    assign lo_sync = lo_s2_q;
    assign hi_sync = hi_s2_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        homed_d = homed_q;
        hcnt_d  = hcnt_q;

        case (state_q)
            ST_UNHOMED: begin
                if (axis.cmd == 2'b11) begin
                    state_d = ST_HOMING;
                    hcnt_d  = '0;
                end
            end
            ST_HOMING: begin
                homed_d = 1'b0;
                if (lo_sync) begin
                    pos_d   = '0;
                    homed_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (hcnt_q >= HOME_MAX_V) begin
                    state_d = ST_FAULT;
                end else if (axis.cmd == 2'b00) begin
                    state_d = ST_UNHOMED;
                end else if (tick) begin
                    idx_d  = idx_q - STEP_INC;
                    hcnt_d = (hcnt_q == HOME_MAX_V) ? hcnt_q : hcnt_q + HC_W'(1);
                end
            end
            ST_IDLE: begin
                case (axis.cmd)
                    2'b01: state_d = ST_FWD;
                    2'b10: state_d = ST_REV;
                    2'b11: begin
                        state_d = ST_HOMING;
                        homed_d = 1'b0;
                        hcnt_d  = '0;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            // A command change takes priority over a tick arriving in the same cycle.
            ST_FWD: begin
                if (axis.cmd != 2'b01) begin
                    state_d = ST_IDLE;
                end else if (tick && (pos_q < POS_MAX_V) && !hi_sync) begin
                    idx_d = idx_q + STEP_INC;
                    pos_d = pos_q + POS_W'(1);
                end
            end
            ST_REV: begin
                if (axis.cmd != 2'b10) begin
                    state_d = ST_IDLE;
                end else if (tick && (pos_q != '0) && !lo_sync) begin
                    idx_d = idx_q - STEP_INC;
                    pos_d = pos_q - POS_W'(1);
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_UNHOMED;
        endcase

        // Both limit switches closed means broken wiring: freeze everything and fault.
        if ((state_q != ST_UNHOMED) && lo_sync && hi_sync) begin
            state_d = ST_FAULT;
            idx_d   = idx_q;
            pos_d   = pos_q;
            homed_d = homed_q;
            hcnt_d  = hcnt_q;
        end
    end

    always_comb begin
        coil_d     = ((state_d == ST_UNHOMED) || (state_d == ST_FAULT)) ? 4'b0000 : phase_coil(idx_d);
        busy_d     = (state_d == ST_HOMING) || (state_d == ST_FWD) || (state_d == ST_REV);
        at_limit_d = homed_d && ((pos_d == '0) || (pos_d == POS_MAX_V) || lo_sync || hi_sync);
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_UNHOMED;
            idx_q      <= '0;
            pos_q      <= '0;
            homed_q    <= 1'b0;
            hcnt_q     <= '0;
            coil_q     <= 4'b0000;
            busy_q     <= 1'b0;
            at_limit_q <= 1'b0;
            fault_q    <= 1'b0;
            step_s1_q  <= 1'b0;
            step_s2_q  <= 1'b0;
            step_s3_q  <= 1'b0;
            lo_s1_q    <= 1'b0;
            lo_s2_q    <= 1'b0;
            hi_s1_q    <= 1'b0;
            hi_s2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            homed_q    <= homed_d;
            hcnt_q     <= hcnt_d;
            coil_q     <= coil_d;
            busy_q     <= busy_d;
            at_limit_q <= at_limit_d;
            fault_q    <= fault_d;
            step_s1_q  <= step_s1_d;
            step_s2_q  <= step_s2_d;
            step_s3_q  <= step_s3_d;
            lo_s1_q    <= lo_s1_d;
            lo_s2_q    <= lo_s2_d;
            hi_s1_q    <= hi_s1_d;
            hi_s2_q    <= hi_s2_d;
        end
    end

    assign axis.coil     = coil_q;
    assign axis.position = pos_q;
    assign axis.homed    = homed_q;
    assign axis.busy     = busy_q;
    assign axis.at_limit = at_limit_q;
    assign axis.fault    = fault_q;

endmodule

// File: tb/tb_claw_axis_stepper.sv
// Bench for claw_axis_stepper: directed scenarios plus random traffic, every cycle predicted
// by a behavioural axis model and checked by a decoupled scoreboard monitor.
module tb_claw_axis_stepper;

    localparam int POS_W     = 16;
    localparam int POS_MAX   = 10;
    localparam int HALF_STEP = 1;
    localparam int HOME_MAX  = 6;

    localparam int M_UNHOMED = 0;
    localparam int M_HOMING  = 1;
    localparam int M_IDLE    = 2;
    localparam int M_FWD     = 3;
    localparam int M_REV     = 4;
    localparam int M_FAULT   = 5;

    typedef struct packed {
        logic [3:0]       coil;
        logic [POS_W-1:0] position;
        logic             homed;
        logic             busy;
        logic             at_limit;
        logic             fault;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    claw_axis_stepper_if #(.POS_W(POS_W)) axis ();

    claw_axis_stepper #(
        .POS_W(POS_W),
        .POS_MAX(POS_MAX),
        .HALF_STEP(HALF_STEP),
        .HOME_MAX(HOME_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .axis(axis)
    );

    int    tests = 0;
    int    fails = 0;
    snap_t exp_q[$];

    int m_state = M_UNHOMED;
    int m_idx   = 0;
    int m_pos   = 0;
    int m_hcnt  = 0;
    bit m_homed = 1'b0;
    bit sh[4];
    bit lh[3];
    bit hh[3];

    function automatic logic [3:0] phaseCoil(input int i);
        case (i)
            0:       return 4'b1000;
            1:       return 4'b1100;
            2:       return 4'b0100;
            3:       return 4'b0110;
            4:       return 4'b0010;
            5:       return 4'b0011;
            6:       return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic string fmtSnap(input snap_t s);
        return $sformatf("coil=%b pos=%0d homed=%b busy=%b at_limit=%b fault=%b",
                         s.coil, s.position, s.homed, s.busy, s.at_limit, s.fault);
    endfunction

    function automatic snap_t dutSnap();
        snap_t s;
        s.coil     = axis.coil;
        s.position = axis.position;
        s.homed    = axis.homed;
        s.busy     = axis.busy;
        s.at_limit = axis.at_limit;
        s.fault    = axis.fault;
        return s;
    endfunction

    // Reference model: what the axis looks like after one clk edge with these raw inputs.
    // Inputs reach the control logic two edges late; a step is a rising edge seen that late.
    task automatic modelEdge(input logic r, input logic [1:0] c, input logic s,
                             input logic lo, input logic hi, output snap_t o);
        bit tick, los, his;
        int stp;
        stp = (HALF_STEP != 0) ? 1 : 2;
        tick = 1'b0; los = 1'b0; his = 1'b0;
        if (r) begin
            m_state = M_UNHOMED; m_idx = 0; m_pos = 0; m_hcnt = 0; m_homed = 1'b0;
            foreach (sh[i]) sh[i] = 1'b0;
            foreach (lh[i]) lh[i] = 1'b0;
            foreach (hh[i]) hh[i] = 1'b0;
        end else begin
            sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = s;
            lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = lo;
            hh[2] = hh[1]; hh[1] = hh[0]; hh[0] = hi;
            tick = sh[2] && !sh[3];
            los  = lh[2];
            his  = hh[2];
            if (m_state != M_UNHOMED && m_state != M_FAULT && los && his) begin
                m_state = M_FAULT;
            end else begin
                case (m_state)
                    M_UNHOMED: if (c == 2'b11) begin m_state = M_HOMING; m_hcnt = 0; end
                    M_HOMING: begin
                        m_homed = 1'b0;
                        if (los) begin
                            m_pos = 0; m_homed = 1'b1; m_state = M_IDLE;
                        end else if (m_hcnt >= HOME_MAX) begin
                            m_state = M_FAULT;
                        end else if (c == 2'b00) begin
                            m_state = M_UNHOMED;
                        end else if (tick) begin
                            m_idx  = (m_idx + 8 - stp) % 8;
                            m_hcnt = (m_hcnt + 1 > HOME_MAX) ? HOME_MAX : m_hcnt + 1;
                        end
                    end
                    M_IDLE: begin
                        if (c == 2'b01) m_state = M_FWD;
                        else if (c == 2'b10) m_state = M_REV;
                        else if (c == 2'b11) begin m_state = M_HOMING; m_homed = 1'b0; m_hcnt = 0; end
                    end
                    M_FWD: begin
                        if (c != 2'b01) m_state = M_IDLE;
                        else if (tick && m_pos < POS_MAX && !his) begin
                            m_idx = (m_idx + stp) % 8; m_pos = m_pos + 1;
                        end
                    end
                    M_REV: begin
                        if (c != 2'b10) m_state = M_IDLE;
                        else if (tick && m_pos > 0 && !los) begin
                            m_idx = (m_idx + 8 - stp) % 8; m_pos = m_pos - 1;
                        end
                    end
                    default: m_state = M_FAULT;
                endcase
            end
        end
        o.coil     = (m_state == M_UNHOMED || m_state == M_FAULT) ? 4'b0000 : phaseCoil(m_idx);
        o.position = POS_W'(m_pos);
        o.homed    = m_homed;
        o.busy     = (m_state == M_HOMING || m_state == M_FWD || m_state == M_REV);
        o.at_limit = m_homed && (m_pos == 0 || m_pos == POS_MAX || los || his);
        o.fault    = (m_state == M_FAULT);
    endtask

    // One clk cycle of stimulus: drive on the falling edge, queue the prediction, return after the edge.
    task automatic applyStimulus(input logic r, input logic [1:0] c, input logic s,
                                 input logic lo, input logic hi);
        snap_t e;
        @(negedge clk);
        rst           = r;
        axis.cmd      = c;
        axis.step_clk = s;
        axis.lim_lo   = lo;
        axis.lim_hi   = hi;
        modelEdge(r, c, s, lo, hi, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] coil, input int pos,
                               input logic homed, input logic busy, input logic at_limit,
                               input logic fault);
        snap_t w, g;
        w.coil = coil; w.position = POS_W'(pos); w.homed = homed;
        w.busy = busy; w.at_limit = at_limit; w.fault = fault;
        g = dutSnap();
        tests++;
        if (g !== w) begin
            fails++;
            $display("[TB] FAIL %s: got %s, want %s", name, fmtSnap(g), fmtSnap(w));
        end
    endtask

    task automatic idle(input int n, input logic [1:0] c, input logic lo, input logic hi);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, c, 1'b0, lo, hi);
    endtask

    task automatic pulses(input int n, input logic [1:0] c, input int hi_len, input int lo_len);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hi_len; j++) applyStimulus(1'b0, c, 1'b1, 1'b0, 1'b0);
            for (int j = 0; j < lo_len; j++) applyStimulus(1'b0, c, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Scoreboard monitor: one prediction per clk edge, compared just after the edge.
    initial begin : monitor
        int    cyc;
        snap_t e;
        snap_t g;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dutSnap();
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("[TB] FAIL cyc%0d: got %s, want %s", cyc, fmtSnap(g), fmtSnap(e));
                end
                cyc++;
            end
        end
    end

    initial begin : stimulus
        int         step_cnt;
        logic       step_lvl;
        logic [1:0] rc;
        logic       rlo, rhi, rr;

        axis.cmd = 2'b00; axis.step_clk = 1'b0; axis.lim_lo = 1'b0; axis.lim_hi = 1'b0;

        repeat (3) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("reset", 4'b0000, 0, 0, 0, 0, 0);

        pulses(3, 2'b01, 1, 2);
        checkOutput("unhomed_ignore", 4'b0000, 0, 0, 0, 0, 0);

        idle(1, 2'b11, 1'b0, 1'b0);
        checkOutput("homing_start", 4'b1000, 0, 0, 1, 0, 0);
        pulses(5, 2'b11, 2, 2);
        checkOutput("home_walk", 4'b0110, 0, 0, 1, 0, 0);
        idle(3, 2'b11, 1'b1, 1'b0);
        checkOutput("homed", 4'b0110, 0, 1, 0, 1, 0);
        idle(1, 2'b00, 1'b1, 1'b0);
        idle(2, 2'b00, 1'b0, 1'b0);

        idle(1, 2'b01, 1'b0, 1'b0);
        pulses(14, 2'b01, 1, 2);
        checkOutput("fwd_bound", 4'b0011, 10, 1, 1, 1, 0);

        idle(2, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        checkOutput("latency_k1", 4'b0011, 10, 1, 1, 1, 0);
        applyStimulus(1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        checkOutput("latency_k2", 4'b0010, 9, 1, 1, 0, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        checkOutput("rev_two", 4'b0110, 8, 1, 1, 0, 0);

        idle(2, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("tick_vs_cmd", 4'b0110, 8, 1, 0, 0, 0);

        idle(1, 2'b01, 1'b0, 1'b0);
        pulses(2, 2'b01, 1, 2);
        repeat (2) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_mid_move", 4'b0000, 0, 0, 0, 0, 0);

        idle(1, 2'b11, 1'b0, 1'b0);
        pulses(6, 2'b11, 1, 2);
        checkOutput("home_6th_step", 4'b0100, 0, 0, 1, 0, 0);
        idle(1, 2'b11, 1'b0, 1'b0);
        checkOutput("home_timeout", 4'b0000, 0, 0, 0, 0, 1);
        pulses(2, 2'b01, 1, 2);
        idle(2, 2'b11, 1'b0, 1'b0);
        checkOutput("fault_sticky", 4'b0000, 0, 0, 0, 0, 1);

        repeat (2) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(1, 2'b11, 1'b0, 1'b0);
        idle(3, 2'b11, 1'b1, 1'b0);
        idle(1, 2'b00, 1'b1, 1'b0);
        idle(3, 2'b00, 1'b1, 1'b1);
        checkOutput("both_limits", 4'b0000, 0, 1, 0, 1, 1);
        idle(2, 2'b01, 1'b0, 1'b0);
        checkOutput("both_limits_sticky", 4'b0000, 0, 1, 0, 1, 1);

        repeat (2) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step_cnt = 0; step_lvl = 1'b0; rc = 2'b11; rlo = 1'b0; rhi = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (step_cnt == 0) begin
                step_lvl = ~step_lvl;
                step_cnt = $urandom_range(1, 4);
            end
            step_cnt--;
            if ($urandom_range(0, 19) == 0) rc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) rlo = ~rlo;
            if ($urandom_range(0, 79) == 0) rhi = ~rhi;
            rr = ($urandom_range(0, 499) == 0) || (m_state == M_FAULT && $urandom_range(0, 9) == 0);
            applyStimulus(rr, rc, step_lvl, rlo, rhi);
        end

        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
